mem_arbiter: RTL

Shares the single DPI-backed physical memory port between instruction fetch (IF) and load/store (LS) once the core moves to a multi-cycle fetch/execute flow. It carries one outstanding transaction at a time over a req/gnt + rvalid protocol. LS has fixed priority over IF, with an anti-starvation counter that forces an IF grant. It sits between the core front end, the LSU and the pmem_read/pmem_write bridge.

---
 rtl/mem_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and load/store.
// One transaction in flight at a time; LS has priority, bounded by an IF anti-starvation counter.
module mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  state_e     state_r;
  state_e     state_nxt_s;
  owner_e     owner_r;
  owner_e     owner_nxt_s;
  owner_e     sel_s;
  logic [3:0] starve_cnt_r;
  logic [3:0] starve_nxt_s;
  logic       accept_s;

  // Requester selection: LS first unless IF has waited through STARVE_MAX LS grants
  always_comb begin
    sel_s = OWN_NONE;
    if (if_req && (!ls_req || (starve_cnt_r == STARVE_LIM))) begin
      sel_s = OWN_IF;
    end else if (ls_req) begin
      sel_s = OWN_LS;
    end else begin
      sel_s = OWN_NONE;
    end
  end

  assign accept_s = (state_r == ST_IDLE) && (sel_s != OWN_NONE) && mem_gnt;

  // State, owner and starvation counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_NONE;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      starve_cnt_r <= starve_nxt_s;
    end
  end

  // Next-state logic; the counter only moves on an accepted grant
  always_comb begin
    state_nxt_s  = state_r;
    owner_nxt_s  = owner_r;
    starve_nxt_s = starve_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_WAIT;
          owner_nxt_s = sel_s;
          if (sel_s == OWN_IF) begin
            starve_nxt_s = 4'd0;
          end else if (if_req) begin
            starve_nxt_s = (starve_cnt_r >= STARVE_LIM) ? STARVE_LIM : starve_cnt_r + 4'd1;
          end else begin
            starve_nxt_s = 4'd0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_nxt_s = ST_IDLE;
          owner_nxt_s = OWN_NONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        owner_nxt_s = OWN_NONE;
      end
    endcase
  end

  // Output decode; everything is forced low while reset is held
  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = {DATA_W{1'b0}};
    ls_rdata  = {DATA_W{1'b0}};
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    mem_wmask = {(DATA_W/8){1'b0}};
    busy      = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          case (sel_s)
            OWN_IF: begin
              mem_req  = 1'b1;
              mem_addr = if_addr;
              if_gnt   = mem_gnt;
            end
            OWN_LS: begin
              mem_req   = 1'b1;
              mem_we    = ls_we;
              mem_addr  = ls_addr;
              mem_wdata = ls_wdata;
              mem_wmask = ls_wmask;
              ls_gnt    = mem_gnt;
            end
            default: begin
              mem_req = 1'b0;
            end
          endcase
        end
        ST_WAIT: begin
          busy = 1'b1;
          // A store ack also returns mem_rdata; the LSU ignores it
          if (mem_rvalid && (owner_r == OWN_IF)) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end else if (mem_rvalid && (owner_r == OWN_LS)) begin
            ls_rvalid = 1'b1;
            ls_rdata  = mem_rdata;
          end else begin
            busy = 1'b1;
          end
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

  mem_arbiter_checker #(.DATA_W(DATA_W)) u_checker (
    .clk       (clk),
    .rst       (rst),
    .if_gnt    (if_gnt),
    .ls_gnt    (ls_gnt),
    .if_rvalid (if_rvalid),
    .ls_rvalid (ls_rvalid),
    .if_rdata  (if_rdata),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .busy      (busy)
  );

endmodule

// Protocol invariants for the arbiter outputs.
module mem_arbiter_checker #(
  parameter int DATA_W = 64
) (
  input logic              clk,
  input logic              rst,
  input logic              if_gnt,
  input logic              ls_gnt,
  input logic              if_rvalid,
  input logic              ls_rvalid,
  input logic [DATA_W-1:0] if_rdata,
  input logic [DATA_W-1:0] ls_rdata,
  input logic              mem_req,
  input logic              mem_gnt,
  input logic              busy
);

  a_gnt_exclusive: assert property (@(posedge clk) disable iff (rst) !(if_gnt && ls_gnt));
  a_rvalid_exclusive: assert property (@(posedge clk) disable iff (rst) !(if_rvalid && ls_rvalid));
  a_gnt_needs_handshake: assert property (@(posedge clk) disable iff (rst)
    (if_gnt || ls_gnt) |-> (mem_req && mem_gnt));
  a_no_req_when_busy: assert property (@(posedge clk) disable iff (rst) busy |-> !mem_req);
  a_if_rdata_quiet: assert property (@(posedge clk) disable iff (rst)
    !if_rvalid |-> (if_rdata == {DATA_W{1'b0}}));
  a_ls_rdata_quiet: assert property (@(posedge clk) disable iff (rst)
    !ls_rvalid |-> (ls_rdata == {DATA_W{1'b0}}));

endmodule
